// File: rtl/cobs_pkg.sv
// cobs_pkg: definitions shared by the COBS encoder and decoder adapters.
//   COBS_DELIMITER   frame delimiter byte on the encoded stream
//   COBS_MAX_CODE    code byte for a full 254-byte group (no implied zero)
//   cobs_dec_state_t decoder parser states
package cobs_pkg;

    localparam logic [7:0] COBS_DELIMITER = 8'h00;
    localparam logic [7:0] COBS_MAX_CODE  = 8'hFF;

    typedef enum logic [1:0] {
        COBS_CODE,
        COBS_DATA,
        COBS_DISCARD
    } cobs_dec_state_t;

endpackage

// File: rtl/axis_adapter_cobs_decoder.sv
// axis_adapter_cobs_decoder: streaming COBS decoder (8-bit AXI-Stream in and out).
// Strips 0x00 delimiters, restores encoded zeros and emits decoded bytes with
// tlast on the final byte of each frame and tuser on the final beat of a bad frame.
//   clk, reset             system clock, synchronous active-high reset
//   encoded_stream_*       COBS bytes in (tdata/tvalid/tready)
//   decoded_stream_*       decoded bytes out (tdata/tvalid/tready/tlast/tuser)
//   frame_count            good frames emitted, saturating
//   error_count            bad-frame beats (tuser=1) emitted, saturating
module axis_adapter_cobs_decoder
    import cobs_pkg::*;
#(
    parameter int unsigned MAX_FRAME_LEN = 1024,
    parameter bit          SYNC_ON_RESET = 1'b1,
    parameter int unsigned ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               encoded_stream_tdata,
    input  logic                     encoded_stream_tvalid,
    output logic                     encoded_stream_tready,
    output logic [7:0]               decoded_stream_tdata,
    output logic                     decoded_stream_tvalid,
    input  logic                     decoded_stream_tready,
    output logic                     decoded_stream_tlast,
    output logic                     decoded_stream_tuser,
    output logic [ERR_CNT_WIDTH-1:0] frame_count,
    output logic [ERR_CNT_WIDTH-1:0] error_count
);

    localparam int unsigned LEN_W = $clog2(MAX_FRAME_LEN + 1);
    localparam cobs_dec_state_t RESET_STATE = SYNC_ON_RESET ? COBS_DISCARD : COBS_CODE;

    cobs_dec_state_t          state_q, state_d;
    logic [7:0]               cnt_q, cnt_d;
    logic                     pend_zero_q, pend_zero_d;
    logic [LEN_W-1:0]         len_q, len_d;
    logic                     h_valid_q, h_valid_d;
    logic [7:0]               h_data_q, h_data_d;
    logic                     o_valid_q, o_valid_d;
    logic [7:0]               o_data_q, o_data_d;
    logic                     o_last_q, o_last_d;
    logic                     o_user_q, o_user_d;
    logic [ERR_CNT_WIDTH-1:0] frame_count_q, frame_count_d;
    logic [ERR_CNT_WIDTH-1:0] error_count_q, error_count_d;

    logic       accept;
    logic       dec_en;
    logic [7:0] dec_byte;
    logic       flush;
    logic       flush_err;

    // Output register only takes a new beat when it is empty or draining this cycle.
    assign encoded_stream_tready = !reset && (!o_valid_q || decoded_stream_tready);
    assign accept = encoded_stream_tvalid && encoded_stream_tready;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pend_zero_d   = pend_zero_q;
        len_d         = len_q;
        h_valid_d     = h_valid_q;
        h_data_d      = h_data_q;
        o_valid_d     = o_valid_q;
        o_data_d      = o_data_q;
        o_last_d      = o_last_q;
        o_user_d      = o_user_q;
        frame_count_d = frame_count_q;
        error_count_d = error_count_q;
        dec_en        = 1'b0;
        dec_byte      = '0;
        flush         = 1'b0;
        flush_err     = 1'b0;

        if (o_valid_q && decoded_stream_tready) begin
            o_valid_d = 1'b0;
        end

        if (accept) begin
            unique case (state_q)
                COBS_CODE: begin
                    if (encoded_stream_tdata == COBS_DELIMITER) begin
                        // Trailing implied zero is never emitted; empty frames produce nothing.
                        flush       = h_valid_q;
                        pend_zero_d = 1'b0;
                        len_d       = '0;
                    end else begin
                        dec_en      = pend_zero_q;
                        cnt_d       = encoded_stream_tdata - 8'd1;
                        pend_zero_d = (encoded_stream_tdata != COBS_MAX_CODE);
                        state_d     = (encoded_stream_tdata != 8'h01) ? COBS_DATA : COBS_CODE;
                    end
                end
                COBS_DATA: begin
                    if (encoded_stream_tdata == COBS_DELIMITER) begin
                        flush       = 1'b1;
                        flush_err   = 1'b1;
                        pend_zero_d = 1'b0;
                        len_d       = '0;
                        state_d     = COBS_CODE;
                    end else begin
                        dec_en   = 1'b1;
                        dec_byte = encoded_stream_tdata;
                        cnt_d    = cnt_q - 8'd1;
                        if (cnt_q == 8'd1) begin
                            state_d = COBS_CODE;
                        end
                    end
                end
                COBS_DISCARD: begin
                    if (encoded_stream_tdata == COBS_DELIMITER) begin
                        pend_zero_d = 1'b0;
                        len_d       = '0;
                        state_d     = COBS_CODE;
                    end
                end
                default: ;
            endcase
        end

        // Length guard runs after the parser so it overrides the parser's next state.
        if (dec_en) begin
            if (len_q == LEN_W'(MAX_FRAME_LEN)) begin
                flush     = 1'b1;
                flush_err = 1'b1;
                len_d     = '0;
                state_d   = COBS_DISCARD;
            end else begin
                len_d = len_q + LEN_W'(1);
                if (h_valid_q) begin
                    o_valid_d = 1'b1;
                    o_data_d  = h_data_q;
                    o_last_d  = 1'b0;
                    o_user_d  = 1'b0;
                end
                h_valid_d = 1'b1;
                h_data_d  = dec_byte;
            end
        end

        // An error flush with nothing held still emits a 0x00 beat so the error is visible.
        if (flush) begin
            o_valid_d = 1'b1;
            o_data_d  = h_valid_q ? h_data_q : 8'h00;
            o_last_d  = 1'b1;
            o_user_d  = flush_err;
            h_valid_d = 1'b0;
            if (flush_err) begin
                if (error_count_q != '1) error_count_d = error_count_q + 1'b1;
            end else begin
                if (frame_count_q != '1) frame_count_d = frame_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RESET_STATE;
            cnt_q         <= '0;
            pend_zero_q   <= 1'b0;
            len_q         <= '0;
            h_valid_q     <= 1'b0;
            h_data_q      <= '0;
            o_valid_q     <= 1'b0;
            o_data_q      <= '0;
            o_last_q      <= 1'b0;
            o_user_q      <= 1'b0;
            frame_count_q <= '0;
            error_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pend_zero_q   <= pend_zero_d;
            len_q         <= len_d;
            h_valid_q     <= h_valid_d;
            h_data_q      <= h_data_d;
            o_valid_q     <= o_valid_d;
            o_data_q      <= o_data_d;
            o_last_q      <= o_last_d;
            o_user_q      <= o_user_d;
            frame_count_q <= frame_count_d;
            error_count_q <= error_count_d;
        end
    end

    assign decoded_stream_tdata  = o_data_q;
    assign decoded_stream_tvalid = o_valid_q;
    assign decoded_stream_tlast  = o_last_q;
    assign decoded_stream_tuser  = o_user_q;
    assign frame_count           = frame_count_q;
    assign error_count           = error_count_q;

endmodule
